// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl -- MEM-stage load/store controller in front of a data cache.
//
// Accepts one access at a time, presents it to the cache as a word-addressed
// request with byte enables and lane-replicated store data, and returns one
// registered response pulse with the extended load result or an error flag.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready     request handshake from the MEM stage
//   req_we              1 = store, 0 = load
//   req_addr            byte address
//   req_wdata           right-aligned store data
//   req_load_type       0 NOREGWRITE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU
//   req_store_size      00 byte, 01 half, 10/11 word
//   mem_req/we/addr/wdata/be  cache request, held stable until mem_ack
//   mem_ack, mem_rdata  cache completion and read word
//   resp_valid          one-cycle response pulse
//   resp_data           extended load result (0 for stores and errors)
//   resp_err            misaligned access (or access timeout)
//   busy                controller not idle; used as pipeline stall
//
// Build option
//   LSU_TIMEOUT_EN      when defined, an access without mem_ack for 255
//                       cycles is abandoned and reported with resp_err=1.
// -----------------------------------------------------------------------------
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_load_type,
  input  logic [1:0]  req_store_size,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        busy
);

  localparam int DATA_W = 32;

  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LH  = 3'd2;
  localparam logic [2:0] LT_LW  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;
  localparam logic [2:0] LT_LHU = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  function automatic logic f_misaligned(input logic       we,
                                        input logic [2:0] lt,
                                        input logic [1:0] sz,
                                        input logic [1:0] a);
    logic mis;
    mis = 1'b0;
    if (we) begin
      case (sz)
        2'b00:   mis = 1'b0;
        2'b01:   mis = a[0];
        default: mis = (a != 2'b00);
      endcase
    end else begin
      case (lt)
        LT_LH, LT_LHU: mis = a[0];
        LT_LW:         mis = (a != 2'b00);
        default:       mis = 1'b0;
      endcase
    end
    return mis;
  endfunction

  // Load types that actually touch memory; NOREGWRITE and 6/7 do not.
  function automatic logic f_load_ok(input logic [2:0] lt);
    return (lt >= LT_LB) && (lt <= LT_LHU);
  endfunction

  function automatic logic [3:0] f_store_be(input logic [1:0] sz,
                                            input logic [1:0] a);
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << a;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [DATA_W-1:0] f_store_wdata(input logic [1:0]        sz,
                                                      input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] w;
    case (sz)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] f_ext_load(input logic [2:0]        lt,
                                                   input logic [1:0]        a,
                                                   input logic [DATA_W-1:0] rd);
    logic signed [7:0]        b;
    logic signed [15:0]       h;
    logic signed [DATA_W-1:0] r;
    b = rd[{a, 3'b000} +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (lt)
      LT_LB:   r = DATA_W'(b);
      LT_LBU:  r = {24'h0, b};
      LT_LH:   r = DATA_W'(h);
      LT_LHU:  r = {16'h0, h};
      LT_LW:   r = rd;
      default: r = '0;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State and registered request
  // ---------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_misaligned;
  logic                w_resp_err_nxt;
  logic [DATA_W-1:0]   w_resp_data_nxt;

  logic [DATA_W-1:0]   r_addr;
  logic [1:0]          r_off;
  logic                r_we;
  logic [2:0]          r_load_type;
  logic [3:0]          r_be;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_resp_valid;
  logic                r_resp_err;
  logic [DATA_W-1:0]   r_resp_data;

  assign req_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign w_accept     = req_valid && req_ready;
  assign w_misaligned = f_misaligned(req_we, req_load_type, req_store_size, req_addr[1:0]);

  // Strobes decode straight from the state register so an asynchronous reset
  // drops them immediately.
  assign mem_req    = (r_state == S_ACCESS);
  assign mem_we     = r_we && (r_state == S_ACCESS);
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_be     = r_be;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_data  = r_resp_data;

`ifdef LSU_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;

  // Held at zero outside ACCESS, so it is clear on every ACCESS entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= 8'd0;
    end else if (r_state != S_ACCESS) begin
      r_tmo_cnt <= 8'd0;
    end else if (!mem_ack) begin
      r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_resp_err_nxt  = 1'b0;
    w_resp_data_nxt = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_misaligned) begin
            w_state_nxt    = S_RESP;
            w_resp_err_nxt = 1'b1;
          end else if (!req_we && !f_load_ok(req_load_type)) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (mem_ack) begin
          w_state_nxt     = S_RESP;
          w_resp_data_nxt = r_we ? '0 : f_ext_load(r_load_type, r_off, mem_rdata);
        end
`ifdef LSU_TIMEOUT_EN
        // Count 254 here means this is the 255th cycle without an ack; an
        // ack in this same cycle is taken by the branch above.
        else if (r_tmo_cnt == 8'd254) begin
          w_state_nxt    = S_RESP;
          w_resp_err_nxt = 1'b1;
        end
`endif
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture at accept, response capture on entry to RESP
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_off        <= 2'b00;
      r_we         <= 1'b0;
      r_load_type  <= 3'd0;
      r_be         <= 4'b0000;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      if (w_accept) begin
        r_addr      <= {req_addr[31:2], 2'b00};
        r_off       <= req_addr[1:0];
        r_we        <= req_we;
        r_load_type <= req_load_type;
        r_be        <= req_we ? f_store_be(req_store_size, req_addr[1:0]) : 4'b1111;
        r_wdata     <= req_we ? f_store_wdata(req_store_size, req_wdata) : '0;
      end
      r_resp_valid <= (w_state_nxt == S_RESP);
      r_resp_err   <= w_resp_err_nxt;
      r_resp_data  <= w_resp_data_nxt;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl -- self-checking bench for lsu_ctrl.
// Table of directed transactions plus hand-written reset, stray-ack and
// (when LSU_TIMEOUT_EN is defined) timeout sequences.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_load_type;
  logic [1:0]  req_store_size;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        busy;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_load_type  (req_load_type),
    .req_store_size (req_store_size),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_be         (mem_be),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_err       (resp_err),
    .busy           (busy)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  lt;
    logic [1:0]  sz;
    logic [31:0] rdata;
    int          delay;
    logic        access;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic        err;
    logic [31:0] data;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          mreq;
  } exp_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];
  exp_t exp_q [$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    req_valid      = 1'b1;
    req_we         = v.we;
    req_addr       = v.addr;
    req_wdata      = v.wdata;
    req_load_type  = v.lt;
    req_store_size = v.sz;
    mem_rdata      = v.rdata;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t  e;
    exp_t  got;
    int    mreq;
    bit    done;
    string nm;
    nm = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({nm, ".req_ready"}, 32'(req_ready), 32'd1);
    drive_req(v);
    e.data = v.data;
    e.err  = v.err;
    e.lat  = v.access ? v.delay + 2 : 1;
    e.mreq = v.access ? v.delay + 1 : 0;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    mreq = 0;
    done = 1'b0;
    for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
      if (mem_req) begin
        mreq++;
        chk({nm, ".busy"},     32'(busy),   32'd1);
        chk({nm, ".mem_addr"}, mem_addr,    {v.addr[31:2], 2'b00});
        chk({nm, ".mem_be"},   32'(mem_be), 32'(v.be));
        chk({nm, ".mem_we"},   32'(mem_we), 32'(v.we));
        if (v.we) chk({nm, ".mem_wdata"}, mem_wdata, v.mwdata);
        mem_ack = (mreq == v.delay + 1);
      end else begin
        mem_ack = 1'b0;
      end
      if (resp_valid) begin
        done = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL %s.scoreboard: response with no expected entry", nm);
        end else begin
          got = exp_q.pop_front();
          chk({nm, ".resp_data"}, resp_data,      got.data);
          chk({nm, ".resp_err"},  32'(resp_err),  32'(got.err));
          chk({nm, ".latency"},   32'(cyc),       32'(got.lat));
          chk({nm, ".mreq_cyc"},  32'(mreq),      32'(got.mreq));
        end
      end else begin
        @(negedge clk);
      end
    end
    mem_ack = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s.timeout: no resp_valid within 300 cycles, required one", nm);
    end else begin
      @(negedge clk);
      chk({nm, ".pulse_end"}, 32'(resp_valid), 32'd0);
      chk({nm, ".idle"},      32'(busy),       32'd0);
    end
  endtask

  initial begin
    vec_t v;
    int   mreq;
    bit   done;

    // we, addr, wdata, lt, sz, rdata, delay, access, be, mwdata, err, data
    vecs[0]  = '{1'b0, 32'h0000_0103, 32'h0, 3'd1, 2'd0, 32'h80FF_0011, 0, 1'b1, 4'b1111, 32'h0, 1'b0, 32'hFFFF_FF80};
    vecs[1]  = '{1'b0, 32'h0000_0202, 32'h0, 3'd5, 2'd0, 32'hBEEF_1234, 5, 1'b1, 4'b1111, 32'h0, 1'b0, 32'h0000_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0301, 32'h0000_00A5, 3'd0, 2'd0, 32'h0, 1, 1'b1, 4'b0010, 32'hA5A5_A5A5, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0402, 32'h0, 3'd3, 2'd0, 32'h1234_5678, 0, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0206, 32'h0, 3'd2, 2'd0, 32'h8001_7FFF, 2, 1'b1, 4'b1111, 32'h0, 1'b0, 32'hFFFF_8001};
    vecs[5]  = '{1'b0, 32'h0000_0101, 32'h0, 3'd4, 2'd0, 32'h1234_F0AB, 0, 1'b1, 4'b1111, 32'h0, 1'b0, 32'h0000_00F0};
    vecs[6]  = '{1'b0, 32'h0000_0500, 32'h0, 3'd3, 2'd0, 32'hDEAD_BEEF, 0, 1'b1, 4'b1111, 32'h0, 1'b0, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, 32'h0000_0502, 32'h1234_5678, 3'd0, 2'd1, 32'h0, 0, 1'b1, 4'b1100, 32'h5678_5678, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 32'h0000_0600, 32'hCAFE_F00D, 3'd0, 2'd2, 32'h0, 3, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 32'h0000_0604, 32'h1122_3344, 3'd0, 2'd3, 32'h0, 0, 1'b1, 4'b1111, 32'h1122_3344, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 32'h0000_0503, 32'h1234_5678, 3'd0, 2'd1, 32'h0, 0, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0};
    vecs[11] = '{1'b1, 32'h0000_0601, 32'h1234_5678, 3'd0, 2'd2, 32'h0, 0, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_0700, 32'h0, 3'd0, 2'd0, 32'hFFFF_FFFF, 0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 32'h0000_0704, 32'h0, 3'd6, 2'd0, 32'hFFFF_FFFF, 0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 32'h0000_0201, 32'h0, 3'd2, 2'd0, 32'hFFFF_FFFF, 0, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0};
    vecs[15] = '{1'b0, 32'h0000_0100, 32'h0, 3'd1, 2'd0, 32'h8080_807F, 1, 1'b1, 4'b1111, 32'h0, 1'b0, 32'h0000_007F};

    rst_n          = 1'b0;
    req_valid      = 1'b0;
    req_we         = 1'b0;
    req_addr       = 32'h0;
    req_wdata      = 32'h0;
    req_load_type  = 3'd0;
    req_store_size = 2'd0;
    mem_ack        = 1'b0;
    mem_rdata      = 32'h0;

    // Reset values while rst_n is held low
    #12;
    chk("rst.mem_req",    32'(mem_req),    32'd0);
    chk("rst.mem_we",     32'(mem_we),     32'd0);
    chk("rst.busy",       32'(busy),       32'd0);
    chk("rst.req_ready",  32'(req_ready),  32'd1);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_err",   32'(resp_err),   32'd0);
    chk("rst.resp_data",  resp_data,       32'd0);
    chk("rst.mem_be",     32'(mem_be),     32'd0);
    chk("rst.mem_addr",   mem_addr,        32'd0);
    chk("rst.mem_wdata",  mem_wdata,       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      run_vec(i, vecs[i]);
    end
    chk("scoreboard.empty", 32'(exp_q.size()), 32'd0);

    // Stray mem_ack while idle must not start anything
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_ack.busy",       32'(busy),       32'd0);
    chk("stray_ack.resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("stray_ack.resp_valid2", 32'(resp_valid), 32'd0);

    // Reset pulse in the middle of an access
    v = '{1'b0, 32'h0000_0800, 32'h0, 3'd3, 2'd0, 32'h5555_AAAA, 0, 1'b1, 4'b1111, 32'h0, 1'b0, 32'h0};
    @(negedge clk);
    drive_req(v);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid.mem_req_before", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.mem_req_async", 32'(mem_req),   32'd0);
    chk("rst_mid.busy",          32'(busy),      32'd0);
    chk("rst_mid.mem_addr",      mem_addr,       32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid.req_ready", 32'(req_ready), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("rst_mid.no_resp%0d", k), 32'(resp_valid | mem_req), 32'd0);
    end

`ifdef LSU_TIMEOUT_EN
    // No ack: abandoned after 255 ACCESS cycles, late ack ignored
    v = '{1'b0, 32'h0000_0900, 32'h0, 3'd3, 2'd0, 32'h1234_5678, 0, 1'b1, 4'b1111, 32'h0, 1'b0, 32'h0};
    @(negedge clk);
    drive_req(v);
    @(negedge clk);
    req_valid = 1'b0;
    mreq = 0;
    done = 1'b0;
    for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
      if (mem_req) mreq++;
      if (resp_valid) begin
        done = 1'b1;
        chk("tmo.resp_err",  32'(resp_err), 32'd1);
        chk("tmo.resp_data", resp_data,     32'd0);
        chk("tmo.mreq_cyc",  32'(mreq),     32'd255);
        chk("tmo.latency",   32'(cyc),      32'd256);
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL tmo.wait: no resp_valid within 400 cycles, required one");
    end
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("tmo.late_ack_resp", 32'(resp_valid), 32'd0);
    chk("tmo.late_ack_busy", 32'(busy),       32'd0);
    @(negedge clk);
    chk("tmo.late_ack_resp2", 32'(resp_valid), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
